// File: rtl/sqrt_pkg.sv
// Shared types and default sizing for the sqrt core sequencer.
package sqrt_pkg;

    localparam int unsigned SQRT_DW      = 16;
    localparam int unsigned SQRT_ITER    = SQRT_DW / 2;
    localparam int unsigned SQRT_TIMEOUT = 32;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StWait,
        StDone
    } seq_state_t;

endpackage

// File: rtl/sqrt_iter_cnt.sv
// Loadable down-counter with a zero flag. Saturates at zero.
// Used for both the core iteration index and the result-wait timeout.
module sqrt_iter_cnt #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic [Width-1:0] cnt_o,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Load takes priority over decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sqrt_sequencer.sv
// Control stage for the iterative sqrt core: accepts an operand, sequences
// load/start/excounter, waits for the core result (with timeout) and holds it
// behind a valid/ready output handshake.
// Optional result self-check enabled by defining SQRT_SEQ_CHECK_EN.
module sqrt_sequencer
    import sqrt_pkg::*;
#(
    parameter int unsigned DW      = SQRT_DW,
    parameter int unsigned ITER    = DW / 2,
    parameter int unsigned TIMEOUT = SQRT_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          load,
    output logic          start,
    output logic [DW-1:0] D,
    output logic [DW-1:0] excounter,
    input  logic [DW-1:0] Q,
    input  logic [DW-1:0] remainder,
    input  logic          ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_root,
    output logic [DW-1:0] out_rem,
    output logic          out_err,
    output logic          busy
`ifdef SQRT_SEQ_CHECK_EN
    ,
    output logic          chk_err
`endif
);

    // Counter must hold both ITER and TIMEOUT.
    localparam int unsigned TW   = $clog2(TIMEOUT + 1);
    localparam int unsigned CntW = (DW > TW) ? DW : TW;

    seq_state_t      state_q, state_d;
    logic [DW-1:0]   d_q, d_d;
    logic [DW-1:0]   root_q, root_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic            err_q, err_d;
    logic            capture;

    logic            cnt_load;
    logic [CntW-1:0] cnt_val;
    logic            cnt_dec;
    logic [CntW-1:0] cnt;
    logic            cnt_zero;

    sqrt_iter_cnt #(
        .Width(CntW)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .load_i    (cnt_load),
        .load_val_i(cnt_val),
        .dec_i     (cnt_dec),
        .cnt_o     (cnt),
        .zero_o    (cnt_zero)
    );

    // Next-state, operand/result capture and counter control.
    always_comb begin
        state_d  = state_q;
        d_d      = d_q;
        root_d   = root_q;
        rem_d    = rem_q;
        err_d    = err_q;
        capture  = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    d_d      = in_data;
                    cnt_load = 1'b1;
                    cnt_val  = CntW'(ITER);
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                state_d = StRun;
            end
            StRun: begin
                // Last iteration: rearm the counter as the wait timeout.
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = CntW'(TIMEOUT);
                    state_d  = StWait;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StWait: begin
                if (ready) begin
                    root_d  = Q;
                    rem_d   = remainder;
                    err_d   = 1'b0;
                    capture = 1'b1;
                    state_d = StDone;
                end else if (cnt_zero) begin
                    root_d  = '0;
                    rem_d   = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, operand and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            d_q     <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    // in_ready is gated by reset so it reads low while reset is held.
    assign in_ready  = (state_q == StIdle) && reset;
    assign load      = (state_q == StLoad);
    assign start     = (state_q == StRun);
    assign excounter = ((state_q == StLoad) || (state_q == StRun)) ? cnt[DW-1:0] : '0;
    assign D         = d_q;
    assign out_valid = (state_q == StDone);
    assign out_root  = root_q;
    assign out_rem   = rem_q;
    assign out_err   = err_q;
    assign busy      = (state_q != StIdle);

`ifdef SQRT_SEQ_CHECK_EN
    logic [2*DW-1:0] chk_root;
    logic [2*DW-1:0] chk_rem;
    logic [2*DW-1:0] chk_sum;
    logic            chk_bad;
    logic            chk_err_q;

    // Verify root^2 + rem == D and rem <= 2*root without overflow.
    always_comb begin
        chk_root = {{DW{1'b0}}, Q};
        chk_rem  = {{DW{1'b0}}, remainder};
        chk_sum  = (chk_root * chk_root) + chk_rem;
        chk_bad  = (chk_sum != {{DW{1'b0}}, d_q}) || (chk_rem > (chk_root << 1));
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk_err_q <= 1'b0;
        end else if (capture && chk_bad) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule
